// File: rtl/servo_pwm_driver.sv
// Frame-synchronous two-channel servo PWM driver (arm + gripper) with a valid/ready command port.
// Define SERVO_SLEW_EN for STEP-limited slewing; otherwise targets load in one frame.
module servo_pwm_driver #(
  parameter int FRAME_CNT   = 1000000,
  parameter int MIN_W       = 15000,
  parameter int MAX_W       = 135000,
  parameter int ARM_INIT    = 118000,
  parameter int GRIP_INIT   = 65000,
  parameter int STEP        = 2500,
  parameter int HOLD_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_sel,
  input  logic [20:0] cmd_width,
  output logic        LEFT_SERVO,
  output logic        GRIPPER_SERVO,
  output logic        busy,
  output logic        done,
  output logic        frame_tick
);
  localparam int W  = 21;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [W-1:0]  C_LAST  = W'(FRAME_CNT - 1);
  localparam logic [W-1:0]  C_MIN   = W'(MIN_W);
  localparam logic [W-1:0]  C_MAX   = W'(MAX_W);
  localparam logic [W-1:0]  C_ARM   = W'(ARM_INIT);
  localparam logic [W-1:0]  C_GRIP  = W'(GRIP_INIT);
  localparam logic [HW-1:0] C_HLAST = HW'(HOLD_FRAMES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [W-1:0]  r_cnt;
  logic [W-1:0]  r_arm_w;
  logic [W-1:0]  r_grip_w;
  logic [W-1:0]  r_tgt;
  logic          r_sel;
  logic [1:0]    r_state;
  logic [HW-1:0] r_hold;

  logic [W-1:0]  w_clamp;
  logic [W-1:0]  w_next;

  assign frame_tick = (r_cnt == C_LAST);
  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_HOLD) & frame_tick & (r_hold == C_HLAST);

  assign w_clamp = (cmd_width < C_MIN) ? C_MIN :
                   (cmd_width > C_MAX) ? C_MAX : cmd_width;

`ifdef SERVO_SLEW_EN
  localparam logic [W-1:0] C_STEP = W'(STEP);
  logic [W-1:0] w_cur;

  assign w_cur = r_sel ? r_grip_w : r_arm_w;

  // Direction is decided before subtracting so the unsigned difference never wraps.
  always_comb begin
    w_next = r_tgt;
    if (r_tgt > w_cur) begin
      if (r_tgt - w_cur > C_STEP) w_next = w_cur + C_STEP;
    end else if (w_cur - r_tgt > C_STEP) begin
      w_next = w_cur - C_STEP;
    end
  end
`else
  logic w_unused_step;

  assign w_unused_step = (STEP != 0);
  assign w_next        = r_tgt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_cnt <= '0;
    else if (frame_tick) r_cnt <= '0;
    else                 r_cnt <= r_cnt + 1'b1;
  end

  // Widths only change on the tick, so the new width starts exactly at counter 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LEFT_SERVO    <= 1'b0;
      GRIPPER_SERVO <= 1'b0;
    end else begin
      LEFT_SERVO    <= (r_cnt < r_arm_w);
      GRIPPER_SERVO <= (r_cnt < r_grip_w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= 1'b0;
      r_tgt    <= '0;
      r_hold   <= '0;
      r_arm_w  <= C_ARM;
      r_grip_w <= C_GRIP;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_sel   <= cmd_sel;
            r_tgt   <= w_clamp;
            r_state <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (frame_tick) begin
            if (r_sel) r_grip_w <= w_next;
            else       r_arm_w  <= w_next;
            if (w_next == r_tgt) begin
              r_state <= S_HOLD;
              r_hold  <= '0;
            end
          end
        end
        S_HOLD: begin
          if (frame_tick) begin
            if (r_hold == C_HLAST) r_state <= S_IDLE;
            else                   r_hold  <= r_hold + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
